// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: the IF stage (fetch) and the MEM stage (lw/sw)
// share one memory over a req/ready handshake. Data accesses win over fetch,
// the pipeline is stalled until its access completes, and a watchdog ends
// accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    // data port
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    // pipeline control
    output logic              stall,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wcnt;
    logic          cur_data;   // access in flight belongs to the data port
    logic          grant_d, grant_f, finish, timeout;

    // State register.
    // NOTE: every flop is written with <= so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: arbitration, completion and watchdog expiry.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        finish    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (d_read | d_write) begin
                    grant_d   = 1'b1;
                    state_nxt = DATA;
                end else if (if_req) begin
                    grant_f   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DATA, FETCH: begin
                // a real completion beats the watchdog in the same cycle
                if (mem_ready) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else if (wcnt == CW'(MAX_WAIT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request, captured read data, done pulses, watchdog and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            wcnt      <= '0;
            cur_data  <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (grant_d || grant_f) begin
                // both d_read and d_write high is issued as a write
                mem_req   <= 1'b1;
                mem_we    <= grant_d & d_write;
                mem_addr  <= grant_d ? d_addr : if_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                cur_data  <= grant_d;
                wcnt      <= '0;
            end else if (finish || timeout) begin
                mem_req <= 1'b0;
                if (timeout) err <= 1'b1;
                if (cur_data) begin
                    d_done <= 1'b1;
                    if (!mem_we) d_rdata <= finish ? mem_rdata : '0;
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= finish ? mem_rdata : '0;
                end
            end else if (state == DATA || state == FETCH) begin
                wcnt <= wcnt + CW'(1);
            end
        end
    end

    // Freeze the pipeline while any held request has not yet seen its done pulse.
    assign stall = ((d_read | d_write) & ~d_done) | (if_req & ~if_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of directed scenarios, hand-written
// sequences for reset, early request drop and stray ready, then randomized
// scenarios predicted by a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] tb_mem  [256];   // contents seen by the responder
    logic [31:0] ref_mem [256];   // contents the model expects
    int          dq[$];           // per-access wait counts, -1 = never ready
    int          req_cyc = 0;
    int          cur_delay = -1;
    int          stray_mode = 0;  // 0 none, 1 always, 2 random ready while idle

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    always @(negedge clk) begin
        if (!mem_req) begin
            req_cyc   = 0;
            mem_ready = (stray_mode == 1) ? 1'b1 :
                        (stray_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
        end else begin
            if (req_cyc == 0) begin
                if (dq.size() > 0) cur_delay = dq.pop_front();
                else               cur_delay = -1;
            end
            if (cur_delay >= 0 && req_cyc == cur_delay) begin
                mem_ready = 1'b1;
                if (mem_we) tb_mem[widx(mem_addr)] = mem_wdata;
                else        mem_rdata = tb_mem[widx(mem_addr)];
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            req_cyc++;
        end
    end

    // ---------------- scenarios ----------------
    typedef struct {
        string       name;
        logic        rd, wr, fetch, preload;
        logic [31:0] daddr, faddr, wdata;
        int          dd, fd;          // wait cycles before ready, -1 = never
        int          exp_d, exp_f;    // cycle of done pulse after request
        logic        exp_we;
        logic [31:0] exp_drd, exp_frd;
    } scn_t;

    logic exp_err = 1'b0;

    function automatic scn_t mk(input string name, input logic rd, wr, fetch, preload,
                                input logic [31:0] daddr, faddr, wdata, input int dd, fd,
                                input int exp_d, exp_f, input logic exp_we,
                                input logic [31:0] exp_drd, exp_frd);
        scn_t s;
        s.name = name; s.rd = rd; s.wr = wr; s.fetch = fetch; s.preload = preload;
        s.daddr = daddr; s.faddr = faddr; s.wdata = wdata; s.dd = dd; s.fd = fd;
        s.exp_d = exp_d; s.exp_f = exp_f; s.exp_we = exp_we;
        s.exp_drd = exp_drd; s.exp_frd = exp_frd;
        return s;
    endfunction

    // Transaction-level model: a data access requested from idle completes
    // 2+wait cycles later; a fetch requested alongside it goes after the data
    // DONE cycle and one idle cycle; a write lands before a same-cycle fetch.
    function automatic scn_t make_random(input int n);
        scn_t s;
        int   kind = $urandom_range(0, 4);
        logic dat;
        s = mk($sformatf("rnd%0d", n), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.fetch = (kind == 0 || kind >= 3);
        s.wr    = (kind == 2 || kind == 4);
        s.rd    = s.wr ? 1'($urandom_range(0, 1)) : (kind == 1 || kind == 3);
        s.daddr = 32'h200 + 32'(4 * $urandom_range(0, 7));
        s.faddr = 32'h200 + 32'(4 * $urandom_range(0, 7));
        s.wdata = $urandom;
        s.dd    = $urandom_range(0, 4);
        s.fd    = $urandom_range(0, 4);
        dat     = s.rd | s.wr;
        s.exp_d = 2 + s.dd;
        s.exp_f = dat ? 5 + s.dd + s.fd : 2 + s.fd;
        s.exp_we  = s.wr;
        s.exp_drd = ref_mem[widx(s.daddr)];
        s.exp_frd = (s.wr && widx(s.daddr) == widx(s.faddr)) ? s.wdata : ref_mem[widx(s.faddr)];
        return s;
    endfunction

    // Drive one scenario from an idle arbiter, hold requests until done, check everything.
    task automatic run_scn(input scn_t s);
        logic        dat = s.rd | s.wr;
        int          got_d = -1, got_f = -1, nd = 0, nf = 0, last, fs;
        logic [31:0] got_drd = '0, got_frd = '0;
        logic        exp_stall;
        if (s.preload) begin
            if (s.rd && !s.wr) begin
                tb_mem[widx(s.daddr)] = s.exp_drd; ref_mem[widx(s.daddr)] = s.exp_drd;
            end
            if (s.fetch) begin
                tb_mem[widx(s.faddr)] = s.exp_frd; ref_mem[widx(s.faddr)] = s.exp_frd;
            end
        end
        if (dat)     dq.push_back(s.dd);
        if (s.fetch) dq.push_back(s.fd);
        d_read = s.rd; d_write = s.wr; d_addr = s.daddr; d_wdata = s.wdata;
        if_req = s.fetch; if_addr = s.faddr;
        last = dat ? s.exp_d : 0;
        if (s.fetch && s.exp_f > last) last = s.exp_f;
        fs = dat ? s.exp_d + 2 : 1;
        for (int k = 1; k <= last + 4; k++) begin
            @(posedge clk); #1;
            if (d_done) begin nd++; if (got_d < 0) begin got_d = k; got_drd = d_rdata; end end
            if (if_done) begin nf++; if (got_f < 0) begin got_f = k; got_frd = if_rdata; end end
            exp_stall = (dat && k < s.exp_d) || (s.fetch && k < s.exp_f);
            check({s.name, " stall"}, 64'(stall), 64'(exp_stall));
            if (dat && k < s.exp_d) begin
                check({s.name, " d mem_req"}, 64'(mem_req), 64'(1));
                check({s.name, " d mem_we"}, 64'(mem_we), 64'(s.exp_we));
                check({s.name, " d mem_addr"}, 64'(mem_addr), 64'(s.daddr));
                if (s.wr) check({s.name, " d mem_wdata"}, 64'(mem_wdata), 64'(s.wdata));
            end
            if (dat && k == s.exp_d) check({s.name, " d req drop"}, 64'(mem_req), 64'(0));
            if (s.fetch && k >= fs && k < s.exp_f) begin
                check({s.name, " f mem_req"}, 64'(mem_req), 64'(1));
                check({s.name, " f mem_we"}, 64'(mem_we), 64'(0));
                check({s.name, " f mem_addr"}, 64'(mem_addr), 64'(s.faddr));
            end
            if (s.fetch && k == s.exp_f) check({s.name, " f req drop"}, 64'(mem_req), 64'(0));
            if (d_done)  begin d_read = 1'b0; d_write = 1'b0; end
            if (if_done) if_req = 1'b0;
            if ((!dat || got_d > 0) && (!s.fetch || got_f > 0)) break;
        end
        d_read = 1'b0; d_write = 1'b0; if_req = 1'b0;
        if (dat) begin
            check({s.name, " d_done cycle"}, 64'(got_d), 64'(s.exp_d));
            check({s.name, " d_done pulses"}, 64'(nd), 64'(1));
            if (s.rd && !s.wr) check({s.name, " d_rdata"}, 64'(got_drd), 64'(s.exp_drd));
            if (s.wr && s.dd >= 0) ref_mem[widx(s.daddr)] = s.wdata;
        end
        if (s.fetch) begin
            check({s.name, " if_done cycle"}, 64'(got_f), 64'(s.exp_f));
            check({s.name, " if_done pulses"}, 64'(nf), 64'(1));
            check({s.name, " if_rdata"}, 64'(got_frd), 64'(s.exp_frd));
        end
        if ((dat && s.dd < 0) || (s.fetch && s.fd < 0)) exp_err = 1'b1;
        check({s.name, " err"}, 64'(err), 64'(exp_err));
        @(posedge clk); #1;   // DONE -> IDLE
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " mem_req"}, 64'(mem_req), 64'(0));
        check({tag, " mem_we"}, 64'(mem_we), 64'(0));
        check({tag, " dones"}, 64'({if_done, d_done}), 64'(0));
        check({tag, " err"}, 64'(err), 64'(0));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, " if_rdata"}, 64'(if_rdata), 64'(0));
        check({tag, " d_rdata"}, 64'(d_rdata), 64'(0));
    endtask

    scn_t tbl[9];

    initial begin
        int got;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            ref_mem[i] = tb_mem[i];
        end
        //            name          rd wr f  pl daddr      faddr      wdata         dd  fd  ed  ef we drd           frd
        tbl[0] = mk("fetch",        0, 0, 1, 1, 32'h0,     32'h40,    32'h0,         0,  0,  0,  2, 0, 32'h0,        32'h8C220004);
        tbl[1] = mk("lw+fetch",     1, 0, 1, 1, 32'h100,   32'h44,    32'h0,         1,  0,  3,  6, 0, 32'h11112222, 32'h33334444);
        tbl[2] = mk("sw wait3",     0, 1, 0, 0, 32'h10,    32'h0,     32'hDEADBEEF,  3,  0,  5,  0, 1, 32'h0,        32'h0);
        tbl[3] = mk("lw after sw",  1, 0, 0, 0, 32'h10,    32'h0,     32'h0,         0,  0,  2,  0, 0, 32'hDEADBEEF, 32'h0);
        tbl[4] = mk("rd+wr",        1, 1, 0, 0, 32'h20,    32'h0,     32'h0BADF00D,  0,  0,  2,  0, 1, 32'h0,        32'h0);
        tbl[5] = mk("wait14",       1, 0, 0, 1, 32'h30,    32'h0,     32'h0,        14,  0, 16,  0, 0, 32'h5A5A5A5A, 32'h0);
        tbl[6] = mk("sw+fetch",     0, 1, 1, 0, 32'h44,    32'h44,    32'hCAFEF00D,  0,  2,  2,  7, 1, 32'h0,        32'hCAFEF00D);
        tbl[7] = mk("lw timeout",   1, 0, 0, 0, 32'h50,    32'h0,     32'h0,        -1,  0, 16,  0, 0, 32'h0,        32'h0);
        tbl[8] = mk("fetch sticky", 0, 0, 1, 0, 32'h0,     32'h10,    32'h0,         0,  1,  0,  3, 0, 32'h0,        32'hDEADBEEF);

        // reset state
        #3;
        reset_checks("reset");
        check("reset stall", 64'(stall), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_scn(tbl[i]);

        // reset while a fetch is in flight
        dq.push_back(100);
        if_req = 1'b1; if_addr = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset mem_req", 64'(mem_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        reset_checks("mid reset");
        exp_err = 1'b0;
        if_req = 1'b0;
        dq.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_scn(mk("fetch after rst", 0, 0, 1, 0, 32'h0, 32'h40, 32'h0, 0, 1, 0, 3, 0, 32'h0, 32'h8C220004));

        // read request dropped after grant still completes
        dq.push_back(2);
        d_read = 1'b1; d_addr = 32'h100;
        @(posedge clk); #1;
        d_read = 1'b0;
        #1;
        check("early drop mem_req", 64'(mem_req), 64'(1));
        check("early drop stall", 64'(stall), 64'(0));
        got = -1;
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk); #1;
            if (d_done && got < 0) begin
                got = k;
                check("early drop d_rdata", 64'(d_rdata), 64'(ref_mem[widx(32'h100)]));
            end
        end
        check("early drop d_done cycle", 64'(got), 64'(4));

        // stray mem_ready while idle is ignored
        stray_mode = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("stray mem_req", 64'(mem_req), 64'(0));
            check("stray dones", 64'({if_done, d_done}), 64'(0));
        end
        stray_mode = 2;

        for (int n = 0; n < 40; n++) run_scn(make_random(n));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global timeout: run did not reach its summary");
        $fatal(1, "bench time limit expired");
    end

endmodule
